// File: rtl/sensor_pkg.sv
// Shared constants for the sensor conditioning slice: reading widths, default thresholds,
// counter widths for fast/real timing, and the 12-bit saturating shift used by the target path.
package sensor_pkg;

  localparam int ADC_W = 12;
  localparam int CAD_W = 5;
  localparam int ERR_W = 13;

  localparam int SMPL_W_FAST = 8;
  localparam int SMPL_W_SLOW = 14;
  localparam int WIN_W_FAST  = 12;
  localparam int WIN_W_SLOW  = 24;

  localparam logic [ADC_W-1:0] BATT_THRES_DEF  = 12'hA98;
  localparam logic [ADC_W-1:0] BRAKE_THRES_DEF = 12'h800;
  localparam logic [ADC_W-1:0] TORQUE_MIN_DEF  = 12'h380;

  localparam logic [CAD_W-1:0] CAD_MAX = 5'd31;

  // prod >> 4, clamped to full scale when the shifted value needs a 13th bit.
  function automatic logic [ADC_W-1:0] sat12(input logic [16:0] prod);
    logic [12:0] shr;
    shr = prod[16:4];
    return shr[12] ? 12'hFFF : shr[11:0];
  endfunction

endpackage

// File: rtl/sensor_cond_if.sv
// A2D readings and cadence pulse into the conditioner, conditioned drive quantities out.
// No handshake: inputs are level samples, outputs are registered levels valid every cycle.
interface sensor_cond_if;
  import sensor_pkg::*;

  logic [ADC_W-1:0] batt;
  logic [ADC_W-1:0] curr;
  logic [ADC_W-1:0] brake;
  logic [ADC_W-1:0] torque;
  logic             cadence_raw;

  logic [ADC_W-1:0] avg_curr;
  logic [ADC_W-1:0] avg_torque;
  logic [CAD_W-1:0] cadence_vec;
  logic             pedaling;
  logic             lowbatt;
  logic             brake_act;
  logic [ADC_W-1:0] target_curr;
  logic [ERR_W-1:0] error;

  modport master (
    output batt, curr, brake, torque, cadence_raw,
    input  avg_curr, avg_torque, cadence_vec, pedaling, lowbatt, brake_act, target_curr, error
  );

  modport slave (
    input  batt, curr, brake, torque, cadence_raw,
    output avg_curr, avg_torque, cadence_vec, pedaling, lowbatt, brake_act, target_curr, error
  );
endinterface

// File: rtl/sensor_cond_cadence_meas.sv
// Cadence measurement: synchronise the raw pedal pulse, detect rising edges and report the
// saturating edge count once per window.
module cadence_meas
  import sensor_pkg::*;
#(
  parameter int WIN_W = WIN_W_SLOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cadence_raw_i,
  output logic [CAD_W-1:0] cadence_vec_o
);

  logic             s1_q, s2_q, s3_q;
  logic [WIN_W-1:0] win_q;
  logic [CAD_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CAD_W-1:0] vec_q, vec_d;
  logic             rise, term;

  assign rise = s2_q & ~s3_q;
  assign term = &win_q;

  // A rise on the terminal cycle belongs to the window that is closing.
  always_comb begin
    cnt_inc = (rise && (cnt_q != CAD_MAX)) ? cnt_q + 5'd1 : cnt_q;
    cnt_d   = cnt_inc;
    vec_d   = vec_q;
    if (term) begin
      vec_d = cnt_inc;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      win_q <= '0;
      cnt_q <= '0;
      vec_q <= '0;
    end else begin
      s1_q  <= cadence_raw_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      win_q <= win_q + 1'b1;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
    end
  end

  assign cadence_vec_o = vec_q;

endmodule

// File: rtl/sensor_cond.sv
// Sensor conditioning: current/torque filters, battery and brake flags, cadence-scaled
// target current and the current error fed to the motor-drive loop.
module sensor_cond
  import sensor_pkg::*;
#(
  parameter bit               FAST_SIM    = 1'b0,
  parameter logic [ADC_W-1:0] BATT_THRES  = BATT_THRES_DEF,
  parameter logic [ADC_W-1:0] BRAKE_THRES = BRAKE_THRES_DEF,
  parameter logic [ADC_W-1:0] TORQUE_MIN  = TORQUE_MIN_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  sensor_cond_if.slave sns_if
);

  localparam int SMPL_W = FAST_SIM ? SMPL_W_FAST : SMPL_W_SLOW;
  localparam int WIN_W  = FAST_SIM ? WIN_W_FAST  : WIN_W_SLOW;

  logic [SMPL_W-1:0] smpl_q;
  logic              smpl;
  logic [13:0]       cacc_q, cacc_d;
  logic [16:0]       tacc_q, tacc_d;
  logic              ped_q;
  logic              lowbatt_q, brake_q;
  logic [ADC_W-1:0]  target_q, target_d;
  logic [ERR_W-1:0]  error_q, error_d;
  logic [CAD_W-1:0]  cadence_vec;
  logic              pedaling;
  logic [ADC_W-1:0]  avg_curr, avg_torque, tq_ex;
  logic [16:0]       prod;

  cadence_meas #(.WIN_W(WIN_W)) u_cad (
    .clk          (clk),
    .rst_n        (rst_n),
    .cadence_raw_i(sns_if.cadence_raw),
    .cadence_vec_o(cadence_vec)
  );

  assign smpl       = &smpl_q;
  assign pedaling   = (cadence_vec >= 5'd2);
  assign avg_curr   = cacc_q[13:2];
  assign avg_torque = tacc_q[16:5];

  // Torque filter is reseeded when pedaling starts so the average does not ramp from stale data.
  always_comb begin
    cacc_d = cacc_q;
    if (smpl) cacc_d = cacc_q - (cacc_q >> 2) + {2'b00, sns_if.curr};

    tacc_d = tacc_q;
    if (pedaling && !ped_q)  tacc_d = {sns_if.torque, 5'b00000};
    else if (smpl && pedaling) tacc_d = tacc_q - (tacc_q >> 5) + {5'b00000, sns_if.torque};

    tq_ex    = (avg_torque > TORQUE_MIN) ? avg_torque - TORQUE_MIN : '0;
    prod     = {5'b00000, tq_ex} * {12'h000, cadence_vec};
    target_d = (!pedaling || lowbatt_q || brake_q) ? '0 : sat12(prod);
    error_d  = {1'b0, target_q} - {1'b0, avg_curr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_q    <= '0;
      cacc_q    <= '0;
      tacc_q    <= '0;
      ped_q     <= 1'b0;
      lowbatt_q <= 1'b0;
      brake_q   <= 1'b0;
      target_q  <= '0;
      error_q   <= '0;
    end else begin
      smpl_q    <= smpl_q + 1'b1;
      cacc_q    <= cacc_d;
      tacc_q    <= tacc_d;
      ped_q     <= pedaling;
      lowbatt_q <= (sns_if.batt < BATT_THRES);
      brake_q   <= (sns_if.brake < BRAKE_THRES);
      target_q  <= target_d;
      error_q   <= error_d;
    end
  end

  assign sns_if.avg_curr    = avg_curr;
  assign sns_if.avg_torque  = avg_torque;
  assign sns_if.cadence_vec = cadence_vec;
  assign sns_if.pedaling    = pedaling;
  assign sns_if.lowbatt     = lowbatt_q;
  assign sns_if.brake_act   = brake_q;
  assign sns_if.target_curr = target_q;
  assign sns_if.error       = error_q;

endmodule

// File: tb/tb_sensor_cond.sv
// Directed bench for sensor_cond in fast-sim timing: current filter model, cadence window
// scoreboard, torque/target/error points, and a mid-window reset.
module tb_sensor_cond;

  logic clk = 1'b0;
  logic rst_n;

  sensor_cond_if bus ();

  sensor_cond #(.FAST_SIM(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sns_if(bus)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; window and sample boundaries are multiples of 4096 / 256.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  int         cacc_m;
  int         cad_per;
  int         cad_phase;
  logic [12:0] exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_avg_curr"},    bus.avg_curr,    0);
    chk({tag, "_avg_torque"},  bus.avg_torque,  0);
    chk({tag, "_cadence_vec"}, bus.cadence_vec, 0);
    chk({tag, "_pedaling"},    bus.pedaling,    0);
    chk({tag, "_lowbatt"},     bus.lowbatt,     0);
    chk({tag, "_brake_act"},   bus.brake_act,   0);
    chk({tag, "_target_curr"}, bus.target_curr, 0);
    chk({tag, "_error"},       bus.error,       0);
  endtask

  // Per-cycle work at the falling edge: filter model, window scoreboard, cadence drive.
  task automatic step_cycle();
    int off;
    logic [4:0] e;
    if (cyc > 0 && cyc % 256 == 0) begin
      cacc_m = cacc_m - (cacc_m >> 2) + int'(bus.curr);
      chk("avg_curr_model", bus.avg_curr, cacc_m >> 2);
    end
    if (cyc > 0 && cyc % 4096 == 0) begin
      chk("cad_queue_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cadence_vec", bus.cadence_vec, e);
      end
    end
    if (cad_per == 0) begin
      bus.cadence_raw = 1'b0;
    end else begin
      off = (((cyc - cad_phase) % cad_per) + cad_per) % cad_per;
      bus.cadence_raw = (off == 1) || (off == 2);
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      step_cycle();
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.batt        = 12'h900;
    bus.brake       = 12'hC00;
    bus.curr        = 12'h000;
    bus.torque      = 12'h000;
    bus.cadence_raw = 1'b0;
    cad_per   = 0;
    cad_phase = 0;
    cacc_m    = 0;

    repeat (3) @(negedge clk);
    chk_zero("reset");

    rst_n     = 1'b1;
    cad_per   = 512;
    cad_phase = 0;
    exp_q.push_back(5'd8);
    exp_q.push_back(5'd8);
    exp_q.push_back(5'd8);
    exp_q.push_back(5'd8);
    exp_q.push_back(5'd31);
    exp_q.push_back(5'd8);
    chk("lowbatt_before_edge", bus.lowbatt, 0);

    run_to(1);
    chk("lowbatt_low_batt", bus.lowbatt, 1);
    chk("brake_act_released", bus.brake_act, 0);
    bus.batt   = 12'hC00;
    bus.curr   = 12'h400;
    bus.torque = 12'h700;
    run_to(2);
    chk("lowbatt_cleared", bus.lowbatt, 0);

    run_to(256);
    chk("avg_curr_first_smpl", bus.avg_curr, 12'h100);

    run_to(4096);
    chk("pedaling_rise", bus.pedaling, 1);
    chk("avg_torque_hold", bus.avg_torque, 0);
    run_to(4097);
    chk("avg_torque_reseed", bus.avg_torque, 12'h700);
    chk("target_before_avg", bus.target_curr, 0);
    run_to(4098);
    chk("target_8_per_win", bus.target_curr, 12'h1C0);
    exp_err = 13'h01C0 - 13'(cacc_m >> 2);
    run_to(4099);
    chk("error_positive_neg", bus.error, exp_err);

    // Quiet gap so the shifted pulse train starts cleanly in the next window.
    run_to(8100);
    cad_per = 0;
    run_to(8192);
    chk("avg_curr_settled", bus.avg_curr, 12'h400);
    bus.curr  = 12'h100;
    cad_per   = 512;
    cad_phase = 508;

    run_to(15000);
    chk("avg_curr_0x100", bus.avg_curr, 12'h100);
    chk("error_c0", bus.error, 13'h00C0);
    bus.brake = 12'h100;
    run_to(15001);
    chk("brake_act_set", bus.brake_act, 1);
    chk("target_pre_brake", bus.target_curr, 12'h1C0);
    run_to(15002);
    chk("target_braked", bus.target_curr, 0);
    run_to(15003);
    chk("error_negative", bus.error, 13'h1F00);
    bus.brake = 12'hC00;
    run_to(15005);
    chk("brake_act_clear", bus.brake_act, 0);
    chk("target_restored", bus.target_curr, 12'h1C0);

    run_to(16384);
    cad_per   = 100;
    cad_phase = 0;
    run_to(20480);
    cad_per = 512;
    run_to(20481);
    chk("target_cad31", bus.target_curr, 12'h6C8);

    run_to(24577);
    chk("target_cad8_again", bus.target_curr, 12'h1C0);

    run_to(26000);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    chk("cad_queue_drained", exp_q.size(), 0);
    bus.cadence_raw = 1'b0;
    bus.torque      = 12'hFFF;
    cacc_m          = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(5'd8);
    exp_q.push_back(5'd31);

    run_to(4096);
    cad_per = 100;
    run_to(4097);
    chk("avg_torque_full", bus.avg_torque, 12'hFFF);
    run_to(4098);
    chk("target_full_torque", bus.target_curr, 12'h63F);
    run_to(8193);
    chk("target_saturated", bus.target_curr, 12'hFFF);
    chk("cad_queue_empty_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
